ntt_butterfly: RTL

Fully pipelined radix-2 modular butterfly for the NTT datapath. It accepts one coefficient pair and one twiddle per cycle and produces the butterfly outputs modulo Q after a fixed latency. Its outputs feed the delay lines that realign data before the next stage's memory write-back. There is no back-pressure: a valid input always yields a valid output LAT cycles later.

---
 rtl/ntt_pkg.sv | 17 +
 rtl/modmul_barrett.sv | 61 ++++++
 rtl/shift_delay.sv | 35 +++
 rtl/ntt_butterfly.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pkg
// Brief    : Shared constants for the NTT butterfly datapath.
// Revision : 1.0
// ============================================================================
package ntt_pkg;

    localparam int   Q       = 12289;
    localparam int   K       = $clog2(Q);
    localparam int   MU      = (1 << (2 * K)) / Q;
    localparam int   LAT     = 5;
    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/modmul_barrett.sv
`default_nettype none
// ============================================================================
// Module   : modmul_barrett
// Brief    : 3-stage pipelined a*b mod Q using Barrett reduction.
// Revision : 1.0
// ============================================================================
module modmul_barrett #(
    parameter int DATA = 14,
    parameter int Q    = 12289
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DATA-1:0] a,
    input  logic [DATA-1:0] b,
    output logic [DATA-1:0] p_mod
);

    localparam int c_k  = $clog2(Q);
    localparam int c_pw = 2 * DATA;
    localparam int c_tw = c_pw - c_k + 1;
    localparam int c_mw = c_k + 1;
    localparam int c_ew = c_tw + c_mw;
    localparam logic [c_mw-1:0] c_mu   = c_mw'((64'd1 << (2 * c_k)) / 64'(Q));
    localparam logic [c_pw-1:0] c_q_pw = c_pw'(Q);

    logic [c_pw-1:0] r_prod;
    logic [c_pw-1:0] r_prod_d;
    logic [c_tw-1:0] r_qhat;
    logic [DATA-1:0] r_res;

    logic [c_ew-1:0] w_est;
    logic [c_tw-1:0] w_qhat;
    logic [c_pw-1:0] w_r0;
    logic [c_pw-1:0] w_r1;
    logic [DATA-1:0] w_r2;

    // qhat underestimates the true quotient by at most 2, hence two corrections
    assign w_est  = c_ew'(r_prod[c_pw-1:c_k-1]) * c_ew'(c_mu);
    assign w_qhat = c_tw'(w_est >> (c_k + 1));
    assign w_r0   = r_prod_d - (c_pw'(r_qhat) * c_q_pw);
    assign w_r1   = (w_r0 >= c_q_pw) ? (w_r0 - c_q_pw) : w_r0;
    assign w_r2   = DATA'((w_r1 >= c_q_pw) ? (w_r1 - c_q_pw) : w_r1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= '0;
            r_prod_d <= '0;
            r_qhat   <= '0;
            r_res    <= '0;
        end else begin
            r_prod   <= c_pw'(a) * c_pw'(b);
            r_prod_d <= r_prod;
            r_qhat   <= w_qhat;
            r_res    <= w_r2;
        end
    end

    assign p_mod = r_res;

endmodule
`default_nettype wire

// File: rtl/shift_delay.sv
`default_nettype none
// ============================================================================
// Module   : shift_delay
// Brief    : Parameterised shift-register delay line with asynchronous clear.
// Revision : 1.0
// ============================================================================
module shift_delay #(
    parameter int WIDTH = 1,
    parameter int SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [SHIFT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SHIFT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < SHIFT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[SHIFT-1];

endmodule
`default_nettype wire

// File: rtl/ntt_butterfly.sv
`default_nettype none
// ============================================================================
// Module   : ntt_butterfly
// Brief    : 5-stage radix-2 modular butterfly (CT; GS when NTT_BUTTERFLY_GS_EN).
// Revision : 1.0
// ============================================================================
module ntt_butterfly #(
    parameter int DATA = 14,
    parameter int Q    = ntt_pkg::Q
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_mode,
    input  logic [DATA-1:0] in_a,
    input  logic [DATA-1:0] in_b,
    input  logic [DATA-1:0] in_w,
    output logic            out_valid,
    output logic [DATA-1:0] out_x,
    output logic [DATA-1:0] out_y
);

    // S1 and S5 bracket the 3-stage multiplier
    localparam int              c_shift = ntt_pkg::LAT - 2;
    localparam logic [DATA:0]   c_q     = (DATA+1)'(Q);

    function automatic logic [DATA-1:0] mod_add(input logic [DATA-1:0] x, input logic [DATA-1:0] y);
        logic [DATA:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= c_q) s = s - c_q;
        return s[DATA-1:0];
    endfunction

    function automatic logic [DATA-1:0] mod_sub(input logic [DATA-1:0] x, input logic [DATA-1:0] y);
        logic [DATA:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[DATA]) d = d + c_q;
        return d[DATA-1:0];
    endfunction

    logic            r1_valid;
    logic [DATA-1:0] r1_keep;
    logic [DATA-1:0] r1_mul;
    logic [DATA-1:0] r1_w;
    logic [DATA-1:0] w_keep;
    logic [DATA-1:0] w_mul;
    logic [DATA-1:0] w_keep4;
    logic [DATA-1:0] w_prod;
    logic            w_valid4;
    logic [DATA-1:0] w_x;
    logic [DATA-1:0] w_y;

`ifdef NTT_BUTTERFLY_GS_EN
    logic r1_mode;
    logic w_mode4;

    always_comb begin
        w_keep = in_a;
        w_mul  = in_b;
        if (in_mode == ntt_pkg::MODE_GS) begin
            w_keep = mod_add(in_a, in_b);
            w_mul  = mod_sub(in_a, in_b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r1_mode <= 1'b0;
        else       r1_mode <= in_mode;
    end

    shift_delay #(.WIDTH(1), .SHIFT(c_shift)) u_mode_dly (
        .clk  (clk),
        .rst  (reset),
        .din  (r1_mode),
        .dout (w_mode4)
    );
`else
    logic w_unused_mode;

    assign w_keep        = in_a;
    assign w_mul         = in_b;
    assign w_unused_mode = in_mode;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_keep  <= '0;
            r1_mul   <= '0;
            r1_w     <= '0;
        end else begin
            r1_valid <= in_valid;
            r1_keep  <= w_keep;
            r1_mul   <= w_mul;
            r1_w     <= in_w;
        end
    end

    modmul_barrett #(.DATA(DATA), .Q(Q)) u_mul (
        .clk   (clk),
        .rst   (reset),
        .a     (r1_mul),
        .b     (r1_w),
        .p_mod (w_prod)
    );

    shift_delay #(.WIDTH(DATA), .SHIFT(c_shift)) u_keep_dly (
        .clk  (clk),
        .rst  (reset),
        .din  (r1_keep),
        .dout (w_keep4)
    );

    shift_delay #(.WIDTH(1), .SHIFT(c_shift)) u_valid_dly (
        .clk  (clk),
        .rst  (reset),
        .din  (r1_valid),
        .dout (w_valid4)
    );

    always_comb begin
        w_x = mod_add(w_keep4, w_prod);
        w_y = mod_sub(w_keep4, w_prod);
`ifdef NTT_BUTTERFLY_GS_EN
        if (w_mode4 == ntt_pkg::MODE_GS) begin
            w_x = w_keep4;
            w_y = w_prod;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= w_valid4;
            if (w_valid4) begin
                out_x <= w_x;
                out_y <= w_y;
            end
        end
    end

endmodule
`default_nettype wire
